// File: rtl/ysyx_22041071_if_stage_if.sv
// Bundle of the fetch-stage handshake signals.
//   pc_*       : fetch request from the PC generator (valid/ready)
//   axi_ar_*   : AXI read-address channel
//   axi_r_*    : AXI read-data channel
//   id_*       : instruction presented to decode (valid/ready)
// modport master : the fetch stage (AXI master, request consumer, decode producer)
// modport slave  : everything around it (PC stage, AXI slave, decode stage)
interface ysyx_22041071_if_stage_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
);
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_addr;
    logic [LEN_W-1:0]  pc_len;
    logic [1:0]        pc_size;
    logic              pc_ready;

    logic              axi_ar_valid;
    logic              axi_ar_ready;
    logic [ADDR_W-1:0] axi_ar_addr;
    logic [LEN_W-1:0]  axi_ar_len;
    logic [1:0]        axi_ar_size;

    logic              axi_r_valid;
    logic              axi_r_ready;
    logic [DATA_W-1:0] axi_r_data;
    logic [1:0]        axi_r_resp;
    logic              axi_r_last;

    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [31:0]       id_inst;
    logic              id_fault;

    modport master (
        input  pc_valid, pc_addr, pc_len, pc_size,
        output pc_ready,
        output axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_size,
        input  axi_ar_ready,
        input  axi_r_valid, axi_r_data, axi_r_resp, axi_r_last,
        output axi_r_ready,
        output id_valid, id_pc, id_inst, id_fault,
        input  id_ready
    );

    modport slave (
        output pc_valid, pc_addr, pc_len, pc_size,
        input  pc_ready,
        input  axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_size,
        output axi_ar_ready,
        output axi_r_valid, axi_r_data, axi_r_resp, axi_r_last,
        input  axi_r_ready,
        input  id_valid, id_pc, id_inst, id_fault,
        output id_ready
    );
endinterface

// File: rtl/ysyx_22041071_if_stage.sv
// Instruction-fetch response stage. Takes one fetch request at a time from the PC
// stage, issues it on the AXI AR channel, captures the 32-bit instruction from the
// first read beat and presents {pc, inst, fault} to decode through a valid/ready
// register. Misaligned requests and error responses produce a faulting NOP.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   flush : discard in-flight / held fetch (redirect)
//   bus   : request, AXI AR/R and decode handshakes (master view)
module ysyx_22041071_if_stage #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
) (
    input logic                      clk,
    input logic                      reset,
    input logic                      flush,
    ysyx_22041071_if_stage_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StAr, StR, StHold} state_e;

    state_e            state;
    logic              drop;      // current transaction was flushed; drain without capture
    logic              first;     // next R beat is the first of the burst
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [1:0]        req_size;
    logic              ar_valid;
    logic              r_ready;
    logic              id_valid;
    logic              id_fault;
    logic [ADDR_W-1:0] id_pc;
    logic [31:0]       id_inst;

    logic              pc_ready;
    logic              accept;
    logic              aligned;
    logic [31:0]       beat_word;

    always_comb begin
        pc_ready  = (state == StIdle) || (state == StHold && bus.id_ready && !flush);
        accept    = bus.pc_valid && pc_ready;
        aligned   = (bus.pc_addr[1:0] == 2'b00);
        beat_word = req_addr[2] ? bus.axi_r_data[DATA_W-1 -: 32] : bus.axi_r_data[31:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            drop     <= 1'b0;
            first    <= 1'b0;
            req_addr <= '0;
            req_len  <= '0;
            req_size <= '0;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            id_valid <= 1'b0;
            id_fault <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else begin
            case (state)
                StIdle: ;
                StAr: begin
                    // AR must stay up until accepted even when flushed
                    if (flush) drop <= 1'b1;
                    if (bus.axi_ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        first    <= 1'b1;
                        state    <= StR;
                    end
                end
                StR: begin
                    if (flush) drop <= 1'b1;
                    if (bus.axi_r_valid) begin
                        first <= 1'b0;
                        if (first && !drop && !flush) begin
                            if (bus.axi_r_resp != 2'b00) begin
                                id_inst  <= NOP;
                                id_fault <= 1'b1;
                            end else begin
                                id_inst  <= beat_word;
                                id_fault <= 1'b0;
                            end
                        end
                        if (bus.axi_r_last) begin
                            r_ready <= 1'b0;
                            if (drop || flush) begin
                                drop  <= 1'b0;
                                state <= StIdle;
                            end else begin
                                id_valid <= 1'b1;
                                state    <= StHold;
                            end
                        end
                    end
                end
                StHold: begin
                    if (flush || bus.id_ready) begin
                        id_valid <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // New request; only possible from IDLE or a draining HOLD, so it
            // overrides the HOLD exit above for back-to-back operation.
            if (accept) begin
                req_addr <= bus.pc_addr;
                req_len  <= bus.pc_len;
                req_size <= bus.pc_size;
                id_pc    <= bus.pc_addr;
                if (aligned) begin
                    ar_valid <= 1'b1;
                    id_valid <= 1'b0;
                    state    <= StAr;
                end else begin
                    id_valid <= 1'b1;
                    id_fault <= 1'b1;
                    id_inst  <= NOP;
                    state    <= StHold;
                end
            end
        end
    end

    assign bus.pc_ready     = pc_ready;
    assign bus.axi_ar_valid = ar_valid;
    assign bus.axi_ar_addr  = req_addr;
    assign bus.axi_ar_len   = req_len;
    assign bus.axi_ar_size  = req_size;
    assign bus.axi_r_ready  = r_ready;
    assign bus.id_valid     = id_valid;
    assign bus.id_pc        = id_pc;
    assign bus.id_inst      = id_inst;
    assign bus.id_fault     = id_fault;
endmodule
